// File: rtl/neural_acq_pkg.sv
// rtl/neural_acq_pkg.sv - shared state enum, default widths and sample beat type for the ADC sequencer
package neural_acq_pkg;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_CH_ID_WIDTH = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_START,
        S_CONVERT,
        S_EMIT
    } seq_state_e;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0]  data;
        logic [DEF_CH_ID_WIDTH-1:0] channel;
    } sample_beat_t;

endpackage

// File: rtl/acq_frame_timer.sv
// rtl/acq_frame_timer.sv - frame period down-counter, held at zero while disabled, ticks on zero
module acq_frame_timer
    import neural_acq_pkg::*;
#(
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    sensor_clk,
    input  logic                    sensor_rst_n,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] sample_period,
    output logic                    tick
);

    logic [PERIOD_WIDTH-1:0] count;

    // Holding the count at zero while disabled makes the first enabled cycle tick immediately.
    assign tick = enable && (count == '0);

    // Reload on tick (period sampled only here), otherwise count down.
    always_ff @(posedge sensor_clk) begin
        if (!sensor_rst_n) begin
            count <= '0;
        end else if (!enable) begin
            count <= '0;
        end else if (count == '0) begin
            count <= sample_period;
        end else begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/adc_channel_sequencer.sv
// rtl/adc_channel_sequencer.sv - frame-based ADC channel scanner; optional test pattern via ADC_SEQ_TEST_PATTERN_EN
module adc_channel_sequencer
    import neural_acq_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int CH_ID_WIDTH  = DEF_CH_ID_WIDTH,
    parameter int NUM_CH       = 16,
    parameter int PERIOD_WIDTH = 16,
    parameter int CONV_TIMEOUT = 64
) (
    input  logic                    sensor_clk,
    input  logic                    sensor_rst_n,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic [PERIOD_WIDTH-1:0] sample_period,
`ifdef ADC_SEQ_TEST_PATTERN_EN
    input  logic                    test_mode,
`endif
    output logic                    conv_start,
    output logic [CH_ID_WIDTH-1:0]  conv_ch,
    input  logic                    conv_done,
    input  logic [DATA_WIDTH-1:0]   conv_data,
    output logic [DATA_WIDTH-1:0]   adc_data_out,
    output logic [CH_ID_WIDTH-1:0]  adc_channel_out,
    output logic                    adc_valid_out,
    output logic                    frame_done,
    output logic                    overrun_err,
    output logic                    timeout_err
);

    localparam int IDX_WIDTH = CH_ID_WIDTH + 1;
    localparam int TO_WIDTH  = (CONV_TIMEOUT > 1) ? $clog2(CONV_TIMEOUT) : 1;

    seq_state_e             state;
    seq_state_e             state_next;
    logic [NUM_CH-1:0]      frame_mask;
    logic [IDX_WIDTH-1:0]   idx;
    logic [IDX_WIDTH-1:0]   next_idx;
    logic [TO_WIDTH-1:0]    tcnt;
    logic                   tick;
    logic                   found;
    logic [CH_ID_WIDTH-1:0] sel_ch;
    logic                   expired;
    logic                   pattern;
    logic [DATA_WIDTH-1:0]  pattern_data;

    acq_frame_timer #(
        .PERIOD_WIDTH (PERIOD_WIDTH)
    ) u_frame_timer (
        .sensor_clk    (sensor_clk),
        .sensor_rst_n  (sensor_rst_n),
        .enable        (enable),
        .sample_period (sample_period),
        .tick          (tick)
    );

    // idx is one bit wider than a channel ID so that NUM_CH can mean "past the last channel".
    assign next_idx = IDX_WIDTH'(conv_ch) + IDX_WIDTH'(1);
    assign expired  = (tcnt == TO_WIDTH'(CONV_TIMEOUT - 1));

`ifdef ADC_SEQ_TEST_PATTERN_EN
    logic [DATA_WIDTH-CH_ID_WIDTH-1:0] frame_cnt;

    assign pattern      = test_mode;
    assign pattern_data = {conv_ch, frame_cnt};

    // Frame counter feeding the synthetic sample pattern.
    always_ff @(posedge sensor_clk) begin
        if (!sensor_rst_n) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end
`else
    assign pattern      = 1'b0;
    assign pattern_data = '0;
`endif

    // Lowest enabled channel at or above idx; descending loop so the last hit wins.
    always_comb begin
        found  = 1'b0;
        sel_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (frame_mask[i] && (IDX_WIDTH'(i) >= idx)) begin
                found  = 1'b1;
                sel_ch = CH_ID_WIDTH'(i);
            end
        end
    end

    // Next-state and single-cycle strobes.
    always_comb begin
        state_next    = state;
        conv_start    = 1'b0;
        adc_valid_out = 1'b0;
        frame_done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    if (ch_mask != '0) begin
                        state_next = S_SELECT;
                    end else begin
                        frame_done = 1'b1;
                    end
                end
            end
            S_SELECT: begin
                if (!enable) begin
                    state_next = S_IDLE;
                end else if (found) begin
                    state_next = S_START;
                end else begin
                    frame_done = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_START: begin
                conv_start = !pattern;
                state_next = pattern ? S_EMIT : S_CONVERT;
            end
            S_CONVERT: begin
                if (conv_done) begin
                    state_next = S_EMIT;
                end else if (expired) begin
                    state_next = enable ? S_SELECT : S_IDLE;
                end
            end
            S_EMIT: begin
                adc_valid_out = 1'b1;
                state_next    = enable ? S_SELECT : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register, frame bookkeeping, sample capture and sticky error flags.
    always_ff @(posedge sensor_clk) begin
        if (!sensor_rst_n) begin
            state           <= S_IDLE;
            frame_mask      <= '0;
            idx             <= '0;
            conv_ch         <= '0;
            tcnt            <= '0;
            adc_data_out    <= '0;
            adc_channel_out <= '0;
            overrun_err     <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            state <= state_next;
            if (tick && (state != S_IDLE)) begin
                overrun_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (tick && (ch_mask != '0)) begin
                        frame_mask <= ch_mask;
                        idx        <= '0;
                    end
                end
                S_SELECT: begin
                    if (found) begin
                        conv_ch <= sel_ch;
                    end
                end
                S_START: begin
                    tcnt <= '0;
                    if (pattern) begin
                        adc_data_out    <= pattern_data;
                        adc_channel_out <= conv_ch;
                    end
                end
                S_CONVERT: begin
                    if (conv_done) begin
                        adc_data_out    <= conv_data;
                        adc_channel_out <= conv_ch;
                    end else if (expired) begin
                        timeout_err <= 1'b1;
                        idx         <= next_idx;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_EMIT: begin
                    idx <= next_idx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// tb/tb_adc_channel_sequencer.sv - self-checking bench with ADC responder and frame-level reference model
`timescale 1ns/1ps
module tb_adc_channel_sequencer;
    import neural_acq_pkg::*;

    localparam int DW  = 16;
    localparam int CW  = 4;
    localparam int NCH = 16;
    localparam int PW  = 16;
    localparam int TO  = 64;

    logic           sensor_clk = 1'b0;
    logic           sensor_rst_n;
    logic           enable;
    logic [NCH-1:0] ch_mask;
    logic [PW-1:0]  sample_period;
    logic           conv_start;
    logic [CW-1:0]  conv_ch;
    logic           conv_done;
    logic [DW-1:0]  conv_data;
    logic [DW-1:0]  adc_data_out;
    logic [CW-1:0]  adc_channel_out;
    logic           adc_valid_out;
    logic           frame_done;
    logic           overrun_err;
    logic           timeout_err;
`ifdef ADC_SEQ_TEST_PATTERN_EN
    logic           test_mode = 1'b0;
`endif

    adc_channel_sequencer dut (
        .sensor_clk      (sensor_clk),
        .sensor_rst_n    (sensor_rst_n),
        .enable          (enable),
        .ch_mask         (ch_mask),
        .sample_period   (sample_period),
`ifdef ADC_SEQ_TEST_PATTERN_EN
        .test_mode       (test_mode),
`endif
        .conv_start      (conv_start),
        .conv_ch         (conv_ch),
        .conv_done       (conv_done),
        .conv_data       (conv_data),
        .adc_data_out    (adc_data_out),
        .adc_channel_out (adc_channel_out),
        .adc_valid_out   (adc_valid_out),
        .frame_done      (frame_done),
        .overrun_err     (overrun_err),
        .timeout_err     (timeout_err)
    );

    always #5 sensor_clk = ~sensor_clk;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc = 0;
    int fd_cnt = 0;
    int cs_cnt = 0;
    int cs_wide = 0;
    int lat_bad = 0;
    int last_done_cyc = -10;
    int cs0_prev = 0;
    int cs0_last = 0;
    int to_rise = 0;
    bit prev_cs = 0;
    bit prev_to = 0;
    sample_beat_t mon_b;
    sample_beat_t obs_q[$];
    sample_beat_t exp_q[$];

    int             rsp_delay[NCH];
    logic [DW-1:0]  rsp_data[NCH];
    logic [NCH-1:0] mute_mask = '0;
    int             inject_seq = 0;
    int             inject_seen = 0;

    // Observe outputs mid-cycle: collect beats, count strobes, measure latencies.
    always @(negedge sensor_clk) begin
        cyc++;
        if (adc_valid_out) begin
            mon_b.data    = adc_data_out;
            mon_b.channel = adc_channel_out;
            obs_q.push_back(mon_b);
            if (last_done_cyc != cyc - 1) lat_bad++;
        end
        if (conv_done) last_done_cyc = cyc;
        if (frame_done) fd_cnt++;
        if (conv_start) begin
            cs_cnt++;
            if (prev_cs) cs_wide++;
            if (conv_ch == '0) begin
                cs0_prev = cs0_last;
                cs0_last = cyc;
            end
        end
        if (timeout_err && !prev_to) to_rise = cyc;
        prev_cs = conv_start;
        prev_to = timeout_err;
    end

    // ADC model: answers conv_start after rsp_delay cycles unless muted; can also inject a stray pulse.
    initial begin
        conv_done = 1'b0;
        conv_data = '0;
        forever begin
            @(negedge sensor_clk);
            if (inject_seq != inject_seen) begin
                inject_seen = inject_seq;
                @(posedge sensor_clk);
                #1 conv_done = 1'b1;
                conv_data = 16'hDEAD;
                @(posedge sensor_clk);
                #1 conv_done = 1'b0;
            end else if (conv_start && !mute_mask[conv_ch]) begin
                automatic int ch = int'(conv_ch);
                repeat (rsp_delay[ch]) @(posedge sensor_clk);
                #1 conv_done = 1'b1;
                conv_data = rsp_data[ch];
                @(posedge sensor_clk);
                #1 conv_done = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    task automatic step();
        @(posedge sensor_clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        sensor_rst_n = 1'b0;
        repeat (3) step();
        sensor_rst_n = 1'b1;
        step();
    endtask

    task automatic push_exp(input int ch, input logic [DW-1:0] d);
        sample_beat_t b;
        b.data    = d;
        b.channel = CW'(ch);
        exp_q.push_back(b);
    endtask

    task automatic set_replies(input int dly, input logic [DW-1:0] base);
        for (int c = 0; c < NCH; c++) begin
            rsp_delay[c] = dly;
            rsp_data[c]  = base + DW'(c);
        end
    endtask

    task automatic run_frames(input string tag, input logic [NCH-1:0] m, input logic [PW-1:0] per,
                              input int n_frames, input int budget);
        int fd0 = fd_cnt;
        int k = 0;
        ch_mask = m;
        sample_period = per;
        enable = 1'b1;
        while ((fd_cnt < fd0 + n_frames) && (k < budget)) begin
            step();
            k++;
        end
        enable = 1'b0;
        repeat (5) step();
        check_eq({tag, " frame_done count"}, fd_cnt - fd0, n_frames);
    endtask

    task automatic compare_beats(input string tag, input int s);
        int n = obs_q.size() - s;
        check_eq({tag, " beat count"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            check_eq($sformatf("%s beat%0d channel", tag, i), obs_q[s+i].channel, exp_q[i].channel);
            check_eq($sformatf("%s beat%0d data", tag, i), obs_q[s+i].data, exp_q[i].data);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int fd0;
        int cs0;
        int k;
        logic [NCH-1:0] m;
        logic exp_to;

        enable = 1'b0;
        ch_mask = '0;
        sample_period = '0;
        set_replies(4, 16'hA000);
        sensor_rst_n = 1'b0;
        repeat (3) step();
        check_eq("reset conv_start", conv_start, 0);
        check_eq("reset adc_valid_out", adc_valid_out, 0);
        check_eq("reset frame_done", frame_done, 0);
        check_eq("reset adc_data_out", adc_data_out, 0);
        check_eq("reset adc_channel_out", adc_channel_out, 0);
        check_eq("reset conv_ch", conv_ch, 0);
        check_eq("reset errors", {overrun_err, timeout_err}, 0);
        sensor_rst_n = 1'b1;
        step();

        // Two frames of mask 0x0005, period 99, 4-cycle ADC.
        s = obs_q.size();
        run_frames("basic", 16'h0005, 16'd99, 2, 500);
        exp_q.delete();
        push_exp(0, 16'hA000); push_exp(2, 16'hA002);
        push_exp(0, 16'hA000); push_exp(2, 16'hA002);
        compare_beats("basic", s);
        check_eq("basic frame spacing", cs0_last - cs0_prev, 100);
        check_eq("basic conv_start width", cs_wide, 0);
        check_eq("basic overrun_err", overrun_err, 0);

        // Stray conv_done in IDLE must not produce a beat.
        s = obs_q.size();
        inject_seq++;
        repeat (10) step();
        check_eq("idle conv_done no beat", obs_q.size() - s, 0);

        // ch0 never answered: timeout, ch1 still emitted.
        do_reset();
        mute_mask = 16'h0001;
        s = obs_q.size();
        run_frames("timeout", 16'h0003, 16'd2000, 1, 500);
        exp_q.delete();
        push_exp(1, 16'hA001);
        compare_beats("timeout", s);
        check_eq("timeout_err set", timeout_err, 1);
        check_eq("timeout delay", to_rise - cs0_last, TO + 1);
        mute_mask = '0;

        // All channels with a short period: overrun, full ordered frame.
        do_reset();
        set_replies(2, 16'hA000);
        s = obs_q.size();
        run_frames("overrun", 16'hFFFF, 16'd10, 1, 1000);
        exp_q.delete();
        for (int c = 0; c < NCH; c++) push_exp(c, 16'hA000 + DW'(c));
        compare_beats("overrun", s);
        check_eq("overrun_err set", overrun_err, 1);
        check_eq("overrun timeout_err", timeout_err, 0);

        // Drop enable while ch1 converts.
        do_reset();
        set_replies(10, 16'hA000);
        ch_mask = 16'h0003;
        sample_period = 16'd2000;
        enable = 1'b1;
        k = 0;
        while (!(conv_start && conv_ch == 4'd1) && k < 200) begin
            step();
            k++;
        end
        check_eq("drop saw ch1 start", k < 200, 1);
        step();
        step();
        enable = 1'b0;
        fd0 = fd_cnt;
        cs0 = cs_cnt;
        s = obs_q.size();
        repeat (60) step();
        exp_q.delete();
        push_exp(1, 16'hA001);
        compare_beats("drop", s);
        check_eq("drop no frame_done", fd_cnt - fd0, 0);
        check_eq("drop no conv_start", cs_cnt - cs0, 0);
        check_eq("drop state idle", 32'(dut.state), 32'(S_IDLE));

        // Randomized frames against the channel-list model.
        for (int it = 0; it < 8; it++) begin
            do_reset();
            m = (it == 0) ? '0 : NCH'($urandom);
            mute_mask = NCH'($urandom & $urandom & $urandom);
            for (int c = 0; c < NCH; c++) begin
                rsp_delay[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 1, TO + 1)
                                                          : $urandom_range(1, 20);
                rsp_data[c]  = DW'($urandom);
            end
            exp_q.delete();
            exp_to = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                if (m[c]) begin
                    if (!mute_mask[c] && rsp_delay[c] <= TO) push_exp(c, rsp_data[c]);
                    else exp_to = 1'b1;
                end
            end
            s = obs_q.size();
            run_frames($sformatf("rand%0d", it), m, 16'd3000, 1, 2500);
            compare_beats($sformatf("rand%0d", it), s);
            check_eq($sformatf("rand%0d timeout_err", it), timeout_err, exp_to);
            check_eq($sformatf("rand%0d overrun_err", it), overrun_err, 0);
        end
        mute_mask = '0;
        check_eq("conv_done to valid latency", lat_bad, 0);
        check_eq("conv_start width all", cs_wide, 0);

`ifdef ADC_SEQ_TEST_PATTERN_EN
        do_reset();
        test_mode = 1'b1;
        cs0 = cs_cnt;
        s = obs_q.size();
        run_frames("pattern", 16'h8000, 16'd50, 2, 300);
        exp_q.delete();
        push_exp(15, 16'hF000);
        push_exp(15, 16'hF001);
        compare_beats("pattern", s);
        check_eq("pattern no conv_start", cs_cnt - cs0, 0);
        test_mode = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
